// File: rtl/guess_pkg.sv
// Shared types and constants for the guess-game round sequencer.
package guess_pkg;
  localparam int DIGIT_W    = 3;
  localparam int NUM_DIGITS = 4;
  localparam int CODE_W     = DIGIT_W * NUM_DIGITS;

  // Taps for x^12+x^6+x^4+x+1, shifting left: bits 11,5,3,0 feed back.
  localparam logic [CODE_W-1:0] LFSR_TAPS = 12'h829;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_PLAY, S_CHK_HIT, S_CHK_NEAR, S_REPORT, S_WIN, S_LOSE
  } state_t;

  // Pull digit idx (0 = bits [2:0]) out of a packed code.
  function automatic logic [DIGIT_W-1:0] get_digit(input logic [CODE_W-1:0] code,
                                                   input logic [1:0] idx);
    return code[int'(idx)*DIGIT_W +: DIGIT_W];
  endfunction
endpackage

// File: rtl/guess_lfsr.sv
// 12-bit Fibonacci LFSR, synchronous reset to SEED, free-running when i_en.
module guess_lfsr import guess_pkg::*; #(
  parameter logic [CODE_W-1:0] SEED = 12'hACE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic [CODE_W-1:0] o_q
);
  logic [CODE_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);
  assign o_q  = r_q;

  // Shift left, feedback into bit 0.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_q <= SEED;
    else if (i_en) r_q <= {r_q[CODE_W-2:0], w_fb};
  end
endmodule

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the 4-digit guess game: arms a secret, gates guess
// editing, scores submits serially (4 hit cycles + 8 near cycles + report),
// counts tries and declares win/lose.
// Optional macro GUESS_TIMEOUT_EN adds a PLAY inactivity timeout that forces
// a zero-score report counted as a try.
module guess_round_ctrl import guess_pkg::*; #(
  parameter int                MAX_TRIES = 8,
  parameter logic [CODE_W-1:0] LFSR_SEED = 12'hACE
`ifdef GUESS_TIMEOUT_EN
  , parameter int              TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_load_secret,
  input  logic [CODE_W-1:0] i_secret_in,
  input  logic              i_submit,
  input  logic [CODE_W-1:0] i_guess_code,
  output logic              o_guess_en,
  output logic              o_busy,
  output logic              o_result_valid,
  output logic [2:0]        o_hits,
  output logic [2:0]        o_near,
  output logic [3:0]        o_tries,
  output logic              o_win,
  output logic              o_lose,
  output logic [CODE_W-1:0] o_secret_reveal,
  output logic              o_timeout
);
  state_t            r_state, w_next;
  logic [CODE_W-1:0] w_lfsr, r_secret, r_guess, r_sin;
  logic              r_ld, r_to, r_rv, r_timeout, r_win, r_lose;
  logic [2:0]        r_idx, r_hit_acc, r_tot, r_hits, r_near;
  logic [3:0]        r_tries;
  logic [2:0]        w_cnt_s, w_cnt_g, w_min;
  logic              w_hit, w_to_fire;

  guess_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(1'b1), .o_q(w_lfsr)
  );

`ifdef GUESS_TIMEOUT_EN
  logic [31:0] r_tcnt;
  // Inactivity counter: zero outside PLAY (so it restarts on entry) and on submit.
  always_ff @(posedge i_clk) begin
    if (i_rst)                            r_tcnt <= '0;
    else if (r_state != S_PLAY || i_submit) r_tcnt <= '0;
    else                                  r_tcnt <= r_tcnt + 32'd1;
  end
  assign w_to_fire = (r_state == S_PLAY) && !i_submit &&
                     (r_tcnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_to_fire = 1'b0;
`endif

  // Per-cycle scoring terms: positional hit at idx, and per-value digit counts.
  always_comb begin
    w_cnt_s = '0;
    w_cnt_g = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (get_digit(r_secret, 2'(d)) == r_idx) w_cnt_s = w_cnt_s + 3'd1;
      if (get_digit(r_guess,  2'(d)) == r_idx) w_cnt_g = w_cnt_g + 3'd1;
    end
  end
  assign w_min = (w_cnt_s < w_cnt_g) ? w_cnt_s : w_cnt_g;
  assign w_hit = get_digit(r_secret, r_idx[1:0]) == get_digit(r_guess, r_idx[1:0]);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_next     = r_state;
    o_guess_en = 1'b0;
    o_busy     = 1'b0;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: if (i_start) w_next = S_ARM;
      S_ARM:  w_next = S_PLAY;
      S_PLAY: begin
        o_guess_en = 1'b1;
        if (i_submit)       w_next = S_CHK_HIT;
        else if (w_to_fire) w_next = S_REPORT;
      end
      S_CHK_HIT: begin
        o_busy = 1'b1;
        if (r_idx == 3'd3) w_next = S_CHK_NEAR;
      end
      S_CHK_NEAR: begin
        o_busy = 1'b1;
        if (r_idx == 3'd7) w_next = S_REPORT;
      end
      S_REPORT: begin
        o_busy = 1'b1;
        if (r_hit_acc == 3'd4 && !r_to)                 w_next = S_WIN;
        else if (5'(r_tries) + 5'd1 == 5'(MAX_TRIES))   w_next = S_LOSE;
        else                                            w_next = S_PLAY;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: secret capture, scoring accumulators, reported results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_secret <= '0; r_guess <= '0; r_sin <= '0; r_ld <= 1'b0; r_to <= 1'b0;
      r_idx <= '0; r_hit_acc <= '0; r_tot <= '0; r_hits <= '0; r_near <= '0;
      r_tries <= '0; r_rv <= 1'b0; r_timeout <= 1'b0; r_win <= 1'b0; r_lose <= 1'b0;
    end else begin
      r_rv      <= 1'b0;
      r_timeout <= 1'b0;
      // Levels track the terminal state and drop on the start that leaves it.
      r_win  <= (r_state == S_WIN)  && !i_start;
      r_lose <= (r_state == S_LOSE) && !i_start;
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: if (i_start) begin
          r_ld  <= i_load_secret;
          r_sin <= i_secret_in;
        end
        S_ARM: begin
          r_secret <= r_ld ? r_sin : w_lfsr;
          r_tries  <= '0;
          r_hits   <= '0;
          r_near   <= '0;
        end
        S_PLAY: begin
          r_idx     <= '0;
          r_hit_acc <= '0;
          r_tot     <= '0;
          r_to      <= w_to_fire;
          if (i_submit) r_guess <= i_guess_code;
        end
        S_CHK_HIT: begin
          r_idx     <= (r_idx == 3'd3) ? 3'd0 : r_idx + 3'd1;
          r_hit_acc <= r_hit_acc + {2'b00, w_hit};
        end
        S_CHK_NEAR: begin
          r_idx <= r_idx + 3'd1;
          r_tot <= r_tot + w_min;
        end
        S_REPORT: begin
          // tot counts hits too, so tot >= hit_acc; a timeout leaves both at 0.
          r_hits    <= r_hit_acc;
          r_near    <= r_tot - r_hit_acc;
          r_tries   <= (r_tries == 4'd15) ? r_tries : r_tries + 4'd1;
          r_rv      <= 1'b1;
          r_timeout <= r_to;
        end
        default: ;
      endcase
    end
  end

  assign o_result_valid  = r_rv;
  assign o_hits          = r_hits;
  assign o_near          = r_near;
  assign o_tries         = r_tries;
  assign o_win           = r_win;
  assign o_lose          = r_lose;
  assign o_timeout       = r_timeout;
  assign o_secret_reveal = r_lose ? r_secret : '0;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// Self-checking bench for guess_round_ctrl (default build, MAX_TRIES=8).
module tb_guess_round_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, load_secret = 1'b0, submit = 1'b0;
  logic [11:0] secret_in = '0, guess_code = '0;
  logic guess_en, busy, result_valid, win, lose, timeout;
  logic [2:0] hits, near;
  logic [3:0] tries;
  logic [11:0] secret_reveal;

  int total = 0, bad = 0;
  logic [11:0] tb_lfsr;
  logic [11:0] exp_secret;

  guess_round_ctrl #(.MAX_TRIES(8), .LFSR_SEED(12'hACE)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_load_secret(load_secret),
    .i_secret_in(secret_in), .i_submit(submit), .i_guess_code(guess_code),
    .o_guess_en(guess_en), .o_busy(busy), .o_result_valid(result_valid),
    .o_hits(hits), .o_near(near), .o_tries(tries), .o_win(win), .o_lose(lose),
    .o_secret_reveal(secret_reveal), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference LFSR from the polynomial x^12+x^6+x^4+x+1.
  always @(posedge clk) begin
    if (rst) tb_lfsr <= 12'hACE;
    else     tb_lfsr <= {tb_lfsr[10:0], tb_lfsr[11] ^ tb_lfsr[5] ^ tb_lfsr[3] ^ tb_lfsr[0]};
  end

  typedef struct { logic [11:0] s; logic [11:0] g; int h; int n; } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  function automatic logic [11:0] rnd_code(input int hi);
    return pk($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
  endfunction

  // Mastermind scoring: exact positions, plus shared digit multiset minus exact.
  function automatic void score(input logic [11:0] s, input logic [11:0] g, output int h, output int n);
    int cs[8];
    int cg[8];
    int tot;
    h = 0; tot = 0;
    for (int v = 0; v < 8; v++) begin cs[v] = 0; cg[v] = 0; end
    for (int i = 0; i < 4; i++) begin
      if (s[3*i +: 3] == g[3*i +: 3]) h++;
      cs[s[3*i +: 3]]++;
      cg[g[3*i +: 3]]++;
    end
    for (int v = 0; v < 8; v++) tot += (cs[v] < cg[v]) ? cs[v] : cg[v];
    n = tot - h;
  endfunction

  function automatic logic [27:0] outs();
    return {guess_en, busy, result_valid, hits, near, tries, win, lose, secret_reveal, timeout};
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; submit = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", 32'(outs()), 32'd0);
  endtask

  task automatic start_game(input logic ld, input logic [11:0] sec);
    start = 1'b1; load_secret = ld; secret_in = sec;
    @(negedge clk);
    start = 1'b0;
    exp_secret = ld ? sec : tb_lfsr;
    @(negedge clk);
    chk("play_guess_en", guess_en, 1);
  endtask

  task automatic do_submit(input logic [11:0] g, input bit with_start, input bit poke, output int lat);
    submit = 1'b1; guess_code = g; start = with_start;
    @(negedge clk);
    submit = 1'b0; start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_in_check", busy, 1);
      if (poke && k == 3) begin submit = 1'b1; guess_code = ~g; end
      if (poke && k == 4) submit = 1'b0;
      if (result_valid) begin lat = k; break; end
    end
  endtask

  task automatic check_result(input string nm, input int lat, input int h, input int n, input int t);
    chk({nm, "_latency"}, lat, 13);
    chk({nm, "_hits"}, hits, h);
    chk({nm, "_near"}, near, n);
    chk({nm, "_tries"}, tries, t);
    chk({nm, "_timeout"}, timeout, 0);
  endtask

  task automatic quiet(input int n, input string nm);
    int cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (result_valid) cnt++;
    end
    chk(nm, cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, h, n, tries_m, ng;
    bit over, ld;
    int rng;
    logic [11:0] g;

    vt[0] = '{pk(1,2,3,4), pk(1,2,3,4), 4, 0};
    vt[1] = '{pk(1,1,2,2), pk(2,2,1,1), 0, 4};
    vt[2] = '{pk(0,0,0,7), pk(0,7,7,7), 2, 0};
    vt[3] = '{pk(0,1,2,3), pk(3,2,1,5), 0, 3};
    vt[4] = '{pk(7,7,7,7), pk(0,0,0,0), 0, 0};
    vt[5] = '{pk(1,1,2,3), pk(1,3,1,2), 1, 3};
    vt[6] = '{pk(0,0,0,0), pk(0,0,0,0), 4, 0};

    do_reset();

    // Single-guess vectors, fresh game each.
    foreach (vt[i]) begin
      do_reset();
      start_game(1'b1, vt[i].s);
      do_submit(vt[i].g, 1'b0, 1'b0, lat);
      check_result($sformatf("vec%0d", i), lat, vt[i].h, vt[i].n, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_win", i), win, (vt[i].h == 4) ? 1 : 0);
      chk($sformatf("vec%0d_guess_en", i), guess_en, (vt[i].h == 4) ? 0 : 1);
      chk($sformatf("vec%0d_lose", i), lose, 0);
    end

    // LFSR-armed game lost after 8 guaranteed-miss guesses; 9th submit dropped.
    do_reset();
    start_game(1'b0, 12'h000);
    for (int t = 1; t <= 8; t++) begin
      g = ~exp_secret;
      score(exp_secret, g, h, n);
      do_submit(g, 1'b0, 1'b0, lat);
      check_result($sformatf("lose_try%0d", t), lat, h, n, t);
      @(negedge clk);
      chk($sformatf("lose_try%0d_lose", t), lose, (t == 8) ? 1 : 0);
      chk($sformatf("lose_try%0d_guess_en", t), guess_en, (t == 8) ? 0 : 1);
    end
    chk("lose_reveal", secret_reveal, exp_secret);
    chk("lose_tries", tries, 8);
    submit = 1'b1; guess_code = exp_secret;
    @(negedge clk);
    submit = 1'b0;
    quiet(20, "ninth_submit_dropped");
    chk("ninth_tries", tries, 8);
    chk("ninth_lose_held", lose, 1);

    // Reset in the middle of the near-count phase.
    do_reset();
    start_game(1'b1, pk(1,2,3,4));
    submit = 1'b1; guess_code = pk(1,2,3,4);
    @(negedge clk);
    submit = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_near_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_near_rst_outputs", 32'(outs()), 32'd0);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    quiet(20, "post_rst_submit_dropped");
    chk("post_rst_guess_en", guess_en, 0);
    chk("post_rst_tries", tries, 0);

    // start coinciding with submit in PLAY; a submit while busy is dropped.
    do_reset();
    start_game(1'b1, pk(0,1,2,3));
    do_submit(pk(3,2,1,5), 1'b1, 1'b1, lat);
    check_result("start_with_submit", lat, 0, 3, 1);
    @(negedge clk);
    chk("start_with_submit_guess_en", guess_en, 1);
    quiet(16, "busy_submit_dropped");
    chk("busy_submit_tries", tries, 1);

    // Randomized games against the scoring model.
    for (int gi = 0; gi < 30; gi++) begin
      do_reset();
      ld  = 1'($urandom_range(0, 1));
      rng = $urandom_range(1, 7);
      start_game(ld, rnd_code(rng));
      tries_m = 0; over = 0;
      ng = $urandom_range(1, 10);
      for (int j = 0; j < ng; j++) begin
        g = ($urandom_range(0, 5) == 0) ? exp_secret : rnd_code(rng);
        if (over) begin
          submit = 1'b1; guess_code = g;
          @(negedge clk);
          submit = 1'b0;
          quiet(16, $sformatf("rnd%0d_over_dropped", gi));
          chk($sformatf("rnd%0d_over_tries", gi), tries, tries_m);
          continue;
        end
        score(exp_secret, g, h, n);
        do_submit(g, 1'b0, 1'b0, lat);
        tries_m++;
        check_result($sformatf("rnd%0d_%0d", gi, j), lat, h, n, tries_m);
        @(negedge clk);
        if (h == 4) begin
          chk($sformatf("rnd%0d_win", gi), win, 1);
          over = 1;
        end else if (tries_m == 8) begin
          chk($sformatf("rnd%0d_lose", gi), lose, 1);
          chk($sformatf("rnd%0d_reveal", gi), secret_reveal, exp_secret);
          over = 1;
        end else begin
          chk($sformatf("rnd%0d_guess_en", gi), guess_en, 1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
